// File: rtl/soin_bpredictor_update_ctrl_pkg.sv
// Shared types and constants for the branch-predictor counter-table update
// controller.
//   state_t          : controller mode (table sweep vs. normal update traffic)
//   BP_CTR_*         : 2-bit saturating counter width and named values
//   BP_DROP_W/MAX    : width and saturation value of the dropped-update counter
package soin_bpredictor_update_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,   // sweeping the table to the initial counter value
    ST_RUN  = 1'b1    // table valid, applying resolved-branch updates
  } state_t;

  localparam int              BP_CTR_WIDTH   = 2;
  localparam logic [1:0]      BP_CTR_WEAK_NT = 2'b01;
  localparam logic [1:0]      BP_CTR_MAX     = 2'b11;
  localparam logic [1:0]      BP_CTR_MIN     = 2'b00;

  localparam int              BP_DROP_W      = 16;
  localparam logic [15:0]     BP_DROP_MAX    = 16'hFFFF;

endpackage

// File: rtl/soin_bpredictor_update_ctrl_fifo.sv
// Small in-order FIFO holding pending counter-table writes {index, counter}.
//   clk, reset : clock, synchronous active-high reset
//   push/wdata : enqueue; accepted when not full, or when full with a pop
//   pop/rdata  : dequeue head; rdata is the current head (valid when !empty)
//   flush      : drop all contents (wins over push/pop)
//   full/empty : occupancy flags
//   level      : registered occupancy, 0..2**DEPTH_L
module soin_bpredictor_update_fifo #(
  parameter int WIDTH   = 15,
  parameter int DEPTH_L = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               pop,
  input  logic               flush,
  output logic [WIDTH-1:0]   rdata,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_L:0]   level
);

  localparam int DEPTH = 1 << DEPTH_L;
  localparam logic [DEPTH_L:0] FULL_CNT = {1'b1, {DEPTH_L{1'b0}}};

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_L-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_L:0]   count;
  logic               do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign level   = count;
  assign rdata   = mem[rd_ptr];

  // A pop frees the head slot in the same edge, so push while full is fine
  // as long as it is paired with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/soin_bpredictor_update_ctrl.sv
// Sequencer for the single write port of the 2-bit predictor counter table.
// After reset or a clear it sweeps every entry to INIT_CTR while holding the
// fetch-side stall; afterwards it turns resolved branches into saturating
// counter writes, queueing those it cannot issue immediately.
//   clk, reset             : clock, synchronous active-high reset
//   execute_ctrl_update    : resolved-branch update valid
//   execute_ctrl_index     : table index from the fetch meta
//   execute_ctrl_ctr       : counter value read at fetch
//   execute_ctrl_dir       : actual direction (1 = taken)
//   soin_ctrl_clear        : request full table re-initialisation
//   ctrl_mem_wraddress/data/wren : registered table write port
//   ctrl_bpredictor_stall  : table invalid, predictions must not be used
//   ctrl_fifo_level        : pending-update FIFO occupancy
//   ctrl_drop_count        : saturating count of dropped updates
module soin_bpredictor_update_ctrl
  import soin_bpredictor_update_ctrl_pkg::*;
#(
  parameter int         INDEX_W      = 13,
  parameter logic [1:0] INIT_CTR     = BP_CTR_WEAK_NT,
  parameter int         FIFO_DEPTH_L = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      execute_ctrl_update,
  input  logic [INDEX_W-1:0]        execute_ctrl_index,
  input  logic [BP_CTR_WIDTH-1:0]   execute_ctrl_ctr,
  input  logic                      execute_ctrl_dir,
  input  logic                      soin_ctrl_clear,
  output logic [INDEX_W-1:0]        ctrl_mem_wraddress,
  output logic [BP_CTR_WIDTH-1:0]   ctrl_mem_data,
  output logic                      ctrl_mem_wren,
  output logic                      ctrl_bpredictor_stall,
  output logic [FIFO_DEPTH_L:0]     ctrl_fifo_level,
  output logic [BP_DROP_W-1:0]      ctrl_drop_count
);

  localparam int ENT_W = INDEX_W + BP_CTR_WIDTH;
  localparam logic [INDEX_W-1:0] SWEEP_LAST = '1;

  state_t                    state_q, state_d;
  logic [INDEX_W-1:0]        sweep_q, sweep_d;
  logic                      wren_d;
  logic [INDEX_W-1:0]        addr_d;
  logic [BP_CTR_WIDTH-1:0]   data_d;
  logic                      stall_d;
  logic                      drop;

  logic                      fifo_push, fifo_pop, fifo_flush;
  logic                      fifo_full, fifo_empty;
  logic [ENT_W-1:0]          fifo_rdata;
  logic [INDEX_W-1:0]        head_idx;
  logic [BP_CTR_WIDTH-1:0]   head_ctr;
  logic [BP_CTR_WIDTH-1:0]   new_ctr;

  // Saturating 2-bit counter step from the value seen at fetch.
  always_comb begin
    new_ctr = execute_ctrl_ctr;
    if (execute_ctrl_dir) begin
      if (execute_ctrl_ctr != BP_CTR_MAX) new_ctr = execute_ctrl_ctr + 1'b1;
    end else begin
      if (execute_ctrl_ctr != BP_CTR_MIN) new_ctr = execute_ctrl_ctr - 1'b1;
    end
  end

  assign head_idx = fifo_rdata[ENT_W-1:BP_CTR_WIDTH];
  assign head_ctr = fifo_rdata[BP_CTR_WIDTH-1:0];

  soin_bpredictor_update_fifo #(
    .WIDTH   (ENT_W),
    .DEPTH_L (FIFO_DEPTH_L)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({execute_ctrl_index, new_ctr}),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (ctrl_fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    wren_d     = 1'b0;
    addr_d     = ctrl_mem_wraddress;
    data_d     = ctrl_mem_data;
    stall_d    = ctrl_bpredictor_stall;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    drop       = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        stall_d = 1'b1;
        if (soin_ctrl_clear) begin
          // Restart the sweep; queued updates survive and land after it.
          sweep_d = '0;
        end else begin
          wren_d  = 1'b1;
          addr_d  = sweep_q;
          data_d  = INIT_CTR;
          sweep_d = sweep_q + 1'b1;
          if (sweep_q == SWEEP_LAST) state_d = ST_RUN;
        end
        // The write port is busy, so every update must queue or be lost.
        if (execute_ctrl_update) begin
          if (fifo_full) drop      = 1'b1;
          else           fifo_push = 1'b1;
        end
      end

      ST_RUN: begin
        stall_d = 1'b0;
        if (soin_ctrl_clear) begin
          // Queued counters describe a table that is about to be wiped, and
          // a same-cycle update is equally stale: discard without counting.
          state_d    = ST_INIT;
          sweep_d    = '0;
          fifo_flush = 1'b1;
          stall_d    = 1'b1;
        end else if (!fifo_empty) begin
          // Older queued writes go first to keep acceptance order.
          fifo_pop  = 1'b1;
          wren_d    = 1'b1;
          addr_d    = head_idx;
          data_d    = head_ctr;
          fifo_push = execute_ctrl_update;
        end else if (execute_ctrl_update) begin
          wren_d = 1'b1;
          addr_d = execute_ctrl_index;
          data_d = new_ctr;
        end
      end

      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q               <= ST_INIT;
      sweep_q               <= '0;
      ctrl_mem_wren         <= 1'b0;
      ctrl_mem_wraddress    <= '0;
      ctrl_mem_data         <= '0;
      ctrl_bpredictor_stall <= 1'b1;
      ctrl_drop_count       <= '0;
    end else begin
      state_q               <= state_d;
      sweep_q               <= sweep_d;
      ctrl_mem_wren         <= wren_d;
      ctrl_mem_wraddress    <= addr_d;
      ctrl_mem_data         <= data_d;
      ctrl_bpredictor_stall <= stall_d;
      if (drop && (ctrl_drop_count != BP_DROP_MAX))
        ctrl_drop_count <= ctrl_drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_soin_bpredictor_update_ctrl.sv
// Scoreboard bench: the driver advances a queue-based reference model each
// cycle and pushes the expected status and table writes; a monitor pops and
// compares after each clock edge.
module tb_soin_bpredictor_update_ctrl;

  localparam int IW    = 4;
  localparam int FL    = 2;
  localparam int NENT  = 1 << IW;
  localparam int DEPTH = 1 << FL;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          execute_ctrl_update = 1'b0;
  logic [IW-1:0] execute_ctrl_index = '0;
  logic [1:0]    execute_ctrl_ctr = '0;
  logic          execute_ctrl_dir = 1'b0;
  logic          soin_ctrl_clear = 1'b0;
  logic [IW-1:0] ctrl_mem_wraddress;
  logic [1:0]    ctrl_mem_data;
  logic          ctrl_mem_wren;
  logic          ctrl_bpredictor_stall;
  logic [FL:0]   ctrl_fifo_level;
  logic [15:0]   ctrl_drop_count;

  always #5 clk = ~clk;

  soin_bpredictor_update_ctrl #(
    .INDEX_W      (IW),
    .INIT_CTR     (2'b01),
    .FIFO_DEPTH_L (FL)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .execute_ctrl_update   (execute_ctrl_update),
    .execute_ctrl_index    (execute_ctrl_index),
    .execute_ctrl_ctr      (execute_ctrl_ctr),
    .execute_ctrl_dir      (execute_ctrl_dir),
    .soin_ctrl_clear       (soin_ctrl_clear),
    .ctrl_mem_wraddress    (ctrl_mem_wraddress),
    .ctrl_mem_data         (ctrl_mem_data),
    .ctrl_mem_wren         (ctrl_mem_wren),
    .ctrl_bpredictor_stall (ctrl_bpredictor_stall),
    .ctrl_fifo_level       (ctrl_fifo_level),
    .ctrl_drop_count       (ctrl_drop_count)
  );

  typedef struct {
    bit wren;
    bit rz;      // reset cycle: address/data must also be zero
    bit stall;
    int level;
    int drops;
  } stat_t;

  typedef struct {
    int idx;
    int val;
  } wr_t;

  stat_t sq[$];
  wr_t   wq[$];
  int    tests = 0;
  int    fails = 0;

  // Reference model state: sweep progress, pending writes, drop total.
  bit    m_sweeping = 1'b1;
  int    m_pos = 0;
  wr_t   m_q[$];
  int    m_drops = 0;

  function automatic int nxt(int c, bit d);
    if (d) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  // One clock of stimulus plus the model's view of what the edge produces.
  task automatic step(bit upd, int idx, int ctr, bit dir, bit clr, bit rst);
    stat_t s;
    wr_t   w;
    wr_t   e;
    bit    wr;
    wr = 1'b0;
    w.idx = 0;
    w.val = 0;
    @(negedge clk);
    reset               = rst;
    execute_ctrl_update = upd;
    execute_ctrl_index  = IW'(idx);
    execute_ctrl_ctr    = 2'(ctr);
    execute_ctrl_dir    = dir;
    soin_ctrl_clear     = clr;
    e.idx = idx;
    e.val = nxt(ctr, dir);
    s.rz  = 1'b0;
    if (rst) begin
      m_sweeping = 1'b1;
      m_pos      = 0;
      m_q.delete();
      m_drops    = 0;
      s.stall    = 1'b1;
      s.rz       = 1'b1;
    end else if (m_sweeping) begin
      if (clr) m_pos = 0;
      else begin
        w.idx = m_pos;
        w.val = 1;
        wr    = 1'b1;
        m_pos++;
        if (m_pos == NENT) m_sweeping = 1'b0;
      end
      if (upd) begin
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else if (m_drops < 65535) m_drops++;
      end
      s.stall = 1'b1;
    end else begin
      if (clr) begin
        m_sweeping = 1'b1;
        m_pos      = 0;
        m_q.delete();
        s.stall    = 1'b1;
      end else begin
        s.stall = 1'b0;
        if (m_q.size() > 0) begin
          w  = m_q.pop_front();
          wr = 1'b1;
          if (upd) m_q.push_back(e);
        end else if (upd) begin
          w  = e;
          wr = 1'b1;
        end
      end
    end
    s.wren  = wr;
    s.level = m_q.size();
    s.drops = m_drops;
    sq.push_back(s);
    if (wr) wq.push_back(w);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares after each edge, independent of the driver.
  initial begin
    stat_t s;
    wr_t   w;
    forever begin
      @(posedge clk);
      #1;
      if (sq.size() > 0) begin
        s = sq.pop_front();
        tests++;
        if (ctrl_mem_wren !== s.wren || ctrl_bpredictor_stall !== s.stall ||
            int'(ctrl_fifo_level) != s.level || int'(ctrl_drop_count) != s.drops) begin
          fails++;
          $display("FAIL status t=%0t: wren=%b stall=%b level=%0d drops=%0d, expected wren=%b stall=%b level=%0d drops=%0d",
                   $time, ctrl_mem_wren, ctrl_bpredictor_stall, ctrl_fifo_level, ctrl_drop_count,
                   s.wren, s.stall, s.level, s.drops);
        end
        if (s.rz) begin
          tests++;
          if (ctrl_mem_wraddress !== '0 || ctrl_mem_data !== '0) begin
            fails++;
            $display("FAIL reset_port t=%0t: addr=%0d data=%0d, expected 0/0",
                     $time, ctrl_mem_wraddress, ctrl_mem_data);
          end
        end
      end
      if (ctrl_mem_wren === 1'b1) begin
        tests++;
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL write t=%0t: unexpected write addr=%0d data=%0d",
                   $time, ctrl_mem_wraddress, ctrl_mem_data);
        end else begin
          w = wq.pop_front();
          if (int'(ctrl_mem_wraddress) != w.idx || int'(ctrl_mem_data) != w.val) begin
            fails++;
            $display("FAIL write t=%0t: addr=%0d data=%0d, expected addr=%0d data=%0d",
                     $time, ctrl_mem_wraddress, ctrl_mem_data, w.idx, w.val);
          end
        end
      end
    end
  end

  initial begin
    // Reset, then the power-on sweep with a burst of 6 updates into it.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    idle(3);
    for (int i = 0; i < 6; i++) step(1, i + 2, i % 4, i[0], 0, 0);
    idle(4);
    // Keep updates flowing across the INIT->RUN boundary: full FIFO in RUN
    // must pop+push each cycle with the level held at the maximum.
    for (int i = 0; i < 8; i++) step(1, 15 - i, i % 4, ~i[0], 0, 0);
    idle(2);
    // Clear with two entries queued and an update in the same cycle.
    step(1, 7, 2, 1, 1, 0);
    idle(NENT + 2);
    // Saturation at both ends via the bypass path.
    step(1, 5, 3, 1, 0, 0);
    idle(1);
    step(1, 5, 0, 0, 0, 0);
    idle(2);
    // Reset landing mid-sweep (at index 9).
    step(0, 0, 0, 0, 0, 1);
    idle(9);
    step(0, 0, 0, 0, 0, 1);
    idle(NENT + 3);
    // Randomized traffic including clears in both modes and rare resets.
    for (int i = 0; i < 4000; i++) begin
      int  idx, ctr;
      bit  upd, dir, clr, rst;
      upd = ($urandom % 3) != 0;
      idx = int'($urandom % NENT);
      ctr = int'($urandom % 4);
      dir = 1'($urandom % 2);
      clr = ($urandom % 80) == 0;
      rst = ($urandom % 700) == 0;
      step(upd, idx, ctr, dir, clr, rst);
    end
    idle(NENT + 6);
    @(posedge clk);
    #3;
    tests++;
    if (sq.size() != 0 || wq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d status and %0d writes outstanding, expected 0/0",
               sq.size(), wq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/soin_bpredictor_update_ctrl.md
Name: soin_bpredictor_update_ctrl

Overview:
Sequences the single write port of the bimodal/gshare 2-bit counter table (mem2x8k). After reset, or on a clear request, it sweeps every entry to a configured initial counter value and stalls fetch-side lookups until the sweep completes. In normal operation it turns execute-stage resolutions into saturating-counter writes. Updates that cannot be written immediately are held in a small in-order FIFO.

Parameters:
INDEX_W, 13, table index width; the table has 2**INDEX_W entries.
INIT_CTR, 2'b01, counter value written by the sweep (weakly not-taken).
FIFO_DEPTH_L, 2, log2 of the update FIFO depth (default 4 entries).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
execute_ctrl_update  in  1  resolved-branch update valid
execute_ctrl_index  in  INDEX_W  table index recorded in the fetch meta
execute_ctrl_ctr  in  2  counter value read at fetch (from meta)
execute_ctrl_dir  in  1  actual direction (1 = taken)
soin_ctrl_clear  in  1  request a full table re-initialisation
ctrl_mem_wraddress  out  INDEX_W  table write address (registered)
ctrl_mem_data  out  2  table write data (registered)
ctrl_mem_wren  out  1  table write enable (registered)
ctrl_bpredictor_stall  out  1  1 while the table is invalid; fetch must not trust predictions
ctrl_fifo_level  out  FIFO_DEPTH_L+1  current FIFO occupancy
ctrl_drop_count  out  16  saturating count of dropped updates

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values: state=INIT, sweep counter=0, FIFO empty, ctrl_mem_wren=0, ctrl_mem_wraddress=0, ctrl_mem_data=0, ctrl_bpredictor_stall=1, ctrl_drop_count=0.
- Reset asserted mid-sweep or mid-run returns everything to the reset values. The sweep restarts at index 0.
- New counter value, computed when an update is accepted:
  - dir=1: new = (ctr==3) ? 3 : ctr+1.
  - dir=0: new = (ctr==0) ? 0 : ctr-1.
  - FIFO entries store {index, new}.
- INIT state:
  - Every cycle registers wren=1, address=sweep, data=INIT_CTR, then increments sweep.
  - The write of index 2**INDEX_W-1 is the last. The next cycle is RUN, with stall=0 in that same cycle.
  - Total sweep length is exactly 2**INDEX_W write cycles.
  - Updates arriving in INIT are pushed to the FIFO; they are dropped if the FIFO is full.
  - soin_ctrl_clear in INIT restarts the sweep at 0 and keeps FIFO contents.
- RUN state, write priority per cycle:
  - FIFO non-empty: pop the head and register its write (wren=1 next cycle). An incoming update is pushed in the same cycle; push+pop while full is accepted.
  - FIFO empty with an incoming update: bypass the FIFO and register the write directly. Latency is 1 cycle from update to wren.
  - Otherwise: wren=0.
- Ordering: writes leave strictly in acceptance order. There is no coalescing of same-index updates.
- soin_ctrl_clear in RUN:
  - Next state is INIT with sweep=0.
  - The FIFO is flushed, because stale counters are obsolete.
  - An update arriving in the clear cycle is discarded and not counted as a drop.
  - stall=1 from the next cycle.
- Drops: an update arriving with the FIFO full and no pop that cycle is dropped. ctrl_drop_count increments and saturates at 16'hFFFF.
- ctrl_fifo_level reflects the registered occupancy after each clock edge.

Decomposition:
- Add to soin_header.v:
  - `BP_CTR_WIDTH (2)
  - `BP_CTR_WEAK_NT (2'b01)
  - `BP_CTR_MAX (2'b11)
  - the meta field positions, so the top level slices execute_bpredictor_meta into index/ctr with named macros.
- Sub-module soin_bpredictor_update_fifo:
  - Synchronous FIFO of {INDEX_W+2} bits with push, pop, flush, full, empty and level.
  - Same-cycle push+pop is legal when full.
- The saturating-counter update stays inline in the controller.

Test Plan:
1. INDEX_W=4, reset for 2 cycles, then release. Required: wren=1 for 16 consecutive cycles, addresses 0..15, data 2'b01, stall=1 throughout. Stall falls in the cycle after the index-15 write.
2. RUN, FIFO empty, updates (idx 5, ctr 3, dir 1) then (idx 5, ctr 0, dir 0). Required: next cycles write (5, 3) and (5, 0); saturation holds with no wrap.
3. During the sweep, send 6 back-to-back updates (FIFO_DEPTH_L=2). Required: first 4 queued (level=4), last 2 dropped (drop_count=2). After the sweep, the 4 writes emerge in order on consecutive cycles.
4. RUN with FIFO holding 2 entries, assert soin_ctrl_clear together with an update. Required: level=0 next cycle, update discarded, drop_count unchanged, full 16-entry sweep from address 0, stall=1.
5. Assert reset at sweep index 9. Required: all outputs return to reset values, then a fresh sweep begins at address 0.
6. FIFO full in RUN with a simultaneous incoming update. Required: head popped and written, incoming update accepted, level stays 4, drop_count unchanged.
